pipe_add: RTL and testbench

PIPE_ADD -- requirements
Module: pipe_add

---
 rtl/cpu_alu_pkg.sv | 18 +
 rtl/add_chunk.sv | 30 +++
 rtl/pipe_add.sv | 137 +++++++++++++
 tb/tb_pipe_add.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_alu_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Package     : cpu_alu_pkg                                            |
// | Description : Shared ALU constants: default datapath width and the   |
// |               add/subtract mode encodings.                           |
// | Revision    : 1.0                                                    |
// +----------------------------------------------------------------------+
package cpu_alu_pkg;

    // Default operand/result width for ALU datapaths
    localparam int ALU_WIDTH = 32;

    // Mode encodings driven onto the 'sub' select
    localparam logic ADD = 1'b0;
    localparam logic SUB = 1'b1;

endpackage : cpu_alu_pkg
`default_nettype wire

// File: rtl/add_chunk.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : add_chunk                                              |
// | Description : Combinational CW-bit adder slice. Reports carry-out    |
// |               and the carry into its MSB, so the last slice of a     |
// |               chain can derive signed overflow.                      |
// | Revision    : 1.0                                                    |
// +----------------------------------------------------------------------+
module add_chunk #(
    parameter int CW = 16
) (
    input  logic [CW-1:0] a,
    input  logic [CW-1:0] b,
    input  logic          cin,
    output logic [CW-1:0] sum,
    output logic          cout,
    output logic          cmsb
);

    logic [CW:0] w_full;

    // One extra bit captures the carry out of the slice
    assign w_full = {1'b0, a} + {1'b0, b} + {{CW{1'b0}}, cin};
    assign sum    = w_full[CW-1:0];
    assign cout   = w_full[CW];
    // Carry into the MSB is recovered from the MSB sum bit: s = a ^ b ^ c
    assign cmsb   = a[CW-1] ^ b[CW-1] ^ w_full[CW-1];

endmodule : add_chunk
`default_nettype wire

// File: rtl/pipe_add.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : pipe_add                                               |
// | Description : Carry-pipelined adder/subtractor. Stage k adds chunk k |
// |               of the operands with the carry registered by stage k-1;|
// |               one global advance signal stalls the whole pipe.       |
// | Revision    : 1.0                                                    |
// +----------------------------------------------------------------------+
module pipe_add
    import cpu_alu_pkg::*;
#(
    parameter int WIDTH  = ALU_WIDTH,
    parameter int STAGES = 2
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             zero
);

    // WIDTH must be a multiple of STAGES; each stage owns one chunk
    localparam int CW = WIDTH / STAGES;

    logic w_adv;
    logic w_unused;

    // Stage-boundary views: index k feeds stage k, index STAGES is the output register
    logic             w_v [STAGES+1];
    logic [WIDTH-1:0] w_a [STAGES+1];
    logic [WIDTH-1:0] w_b [STAGES+1];
    logic [WIDTH-1:0] w_s [STAGES+1];
    logic             w_c [STAGES+1];

    // The pipe moves only when the output slot is empty or being drained
    assign w_adv    = !w_v[STAGES] || out_ready;
    assign in_ready = w_adv;

    // Subtraction folds into addition: invert b and the carry-in
    assign w_v[0] = in_valid;
    assign w_a[0] = a;
    assign w_b[0] = (sub == ADD) ? b : ~b;
    assign w_s[0] = '0;
    assign w_c[0] = cin ^ (sub == SUB);

    assign out_valid = w_v[STAGES];
    assign sum       = w_s[STAGES];
    assign cout      = w_c[STAGES];

    // Operands are fully consumed by the last stage
    assign w_unused = ^{w_a[STAGES], w_b[STAGES]};

    genvar k;
    generate
        for (k = 0; k < STAGES; k++) begin : g_stage
            logic [CW-1:0]    w_chunk;
            logic             w_co;
            logic             w_cm;
            logic [WIDTH-1:0] w_nsum;
            logic             r_v;
            logic [WIDTH-1:0] r_a;
            logic [WIDTH-1:0] r_b;
            logic [WIDTH-1:0] r_s;
            logic             r_c;

            add_chunk #(
                .CW (CW)
            ) u_add (
                .a    (w_a[k][k*CW +: CW]),
                .b    (w_b[k][k*CW +: CW]),
                .cin  (w_c[k]),
                .sum  (w_chunk),
                .cout (w_co),
                .cmsb (w_cm)
            );

            // Merge this stage's chunk into the partial sum travelling alongside
            always_comb begin
                w_nsum                = w_s[k];
                w_nsum[k*CW +: CW]    = w_chunk;
            end

            // Stage register: cleared by reset, loaded on global advance, else held
            always_ff @(posedge clock) begin
                if (!resetn) begin
                    r_v <= 1'b0;
                    r_a <= '0;
                    r_b <= '0;
                    r_s <= '0;
                    r_c <= 1'b0;
                end else if (w_adv) begin
                    r_v <= w_v[k];
                    r_a <= w_a[k];
                    r_b <= w_b[k];
                    r_s <= w_nsum;
                    r_c <= w_co;
                end
            end

            assign w_v[k+1] = r_v;
            assign w_a[k+1] = r_a;
            assign w_b[k+1] = r_b;
            assign w_s[k+1] = r_s;
            assign w_c[k+1] = r_c;

            if (k == STAGES - 1) begin : g_last
                logic r_ovf;
                logic r_zero;

                // Flags are registered with the final chunk so they align with sum
                always_ff @(posedge clock) begin
                    if (!resetn) begin
                        r_ovf  <= 1'b0;
                        r_zero <= 1'b0;
                    end else if (w_adv) begin
                        r_ovf  <= w_co ^ w_cm;
                        r_zero <= (w_nsum == '0);
                    end
                end

                assign ovf  = r_ovf;
                assign zero = r_zero;
            end
        end
    endgenerate

endmodule : pipe_add
`default_nettype wire

// File: tb/tb_pipe_add.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : tb_pipe_add                                            |
// | Description : Self-checking bench for pipe_add (32/2, 8/4, 8/1).     |
// | Revision    : 1.0                                                    |
// +----------------------------------------------------------------------+
module tb_pipe_add;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic        resetn;

    // 32-bit, 2-stage instance
    logic        in_valid, in_ready, cin, sub, out_valid, out_ready, cout, ovf, zero;
    logic [31:0] a, b, sum;

    pipe_add #(.WIDTH(32), .STAGES(2)) u_dut (
        .clock(clock), .resetn(resetn), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin), .sub(sub), .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .cout(cout), .ovf(ovf), .zero(zero)
    );

    // 8-bit instances share stimulus: 4 stages and the degenerate 1 stage
    logic       in_valid8, cin8, sub8;
    logic [7:0] a8, b8;
    logic       in_ready4, out_valid4, cout4, ovf4, zero4;
    logic [7:0] sum4;
    logic       in_ready1, out_valid1, cout1, ovf1, zero1;
    logic [7:0] sum1;

    pipe_add #(.WIDTH(8), .STAGES(4)) u_dut4 (
        .clock(clock), .resetn(resetn), .in_valid(in_valid8), .in_ready(in_ready4),
        .a(a8), .b(b8), .cin(cin8), .sub(sub8), .out_valid(out_valid4), .out_ready(1'b1),
        .sum(sum4), .cout(cout4), .ovf(ovf4), .zero(zero4)
    );

    pipe_add #(.WIDTH(8), .STAGES(1)) u_dut1 (
        .clock(clock), .resetn(resetn), .in_valid(in_valid8), .in_ready(in_ready1),
        .a(a8), .b(b8), .cin(cin8), .sub(sub8), .out_valid(out_valid1), .out_ready(1'b1),
        .sum(sum1), .cout(cout1), .ovf(ovf1), .zero(zero1)
    );

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        cin;
        logic        sub;
        logic [31:0] s;
        logic        c;
        logic        o;
        logic        z;
    } vec_t;

    typedef struct packed {
        logic [31:0] s;
        logic        c;
        logic        o;
        logic        z;
    } res_t;

    vec_t tbl  [11];
    vec_t tbl8 [5];

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Independent reference: WIDTH+1-bit sum, overflow from operand/result signs
    function automatic res_t model32(input logic [31:0] x, input logic [31:0] y,
                                     input logic ci, input logic su);
        logic [31:0] ye;
        logic [32:0] f;
        res_t        r;
        ye  = su ? ~y : y;
        f   = {1'b0, x} + {1'b0, ye} + {32'd0, ci ^ su};
        r.s = f[31:0];
        r.c = f[32];
        r.o = (x[31] == ye[31]) && (r.s[31] != x[31]);
        r.z = (r.s == 32'd0);
        return r;
    endfunction

    // Streams nops operations; rnd=0 stalls the consumer for 3 cycles mid-stream
    task automatic run_stream(input int nops, input bit rnd, input int budget);
        res_t        exp_q[$];
        res_t        e;
        res_t        prev;
        int          sent, got, cyc, stall_seen;
        bit          have_op, prev_hold;
        logic [31:0] na, nb;
        logic        nc, ns;
        sent = 0; got = 0; cyc = 0; stall_seen = 0;
        have_op = 1'b0; prev_hold = 1'b0; prev = '0;
        na = '0; nb = '0; nc = 1'b0; ns = 1'b0;
        while (got < nops && cyc < budget) begin
            @(negedge clock);
            cyc++;
            if (!have_op && sent < nops && (!rnd || $urandom_range(3) != 0)) begin
                if (rnd) begin
                    na = $urandom; nb = $urandom;
                    nc = 1'($urandom_range(1)); ns = 1'($urandom_range(1));
                end else begin
                    na = 32'h1111_1111 * sent; nb = 32'hF0F0_0000 + sent;
                    nc = sent[0]; ns = sent[1];
                end
                have_op = 1'b1;
            end
            in_valid  = have_op;
            a = na; b = nb; cin = nc; sub = ns;
            out_ready = rnd ? ($urandom_range(9) < 7) : !(cyc >= 5 && cyc <= 7);
            #1;
            if (prev_hold)
                chk("hold_stable", {out_valid, sum, cout, ovf, zero}, {1'b1, prev});
            chk("in_ready_rule", in_ready, !out_valid || out_ready);
            if (!rnd && out_valid && !out_ready) begin
                chk("stall_in_ready_low", in_ready, 1'b0);
                stall_seen++;
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("extra_result", {out_valid, sum}, 33'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk($sformatf("result%0d", got), {sum, cout, ovf, zero}, e);
                end
                got++;
            end
            prev_hold = out_valid && !out_ready;
            prev      = {sum, cout, ovf, zero};
            if (in_valid && in_ready) begin
                exp_q.push_back(model32(na, nb, nc, ns));
                sent++;
                have_op = 1'b0;
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        chk("stream_count", got, nops);
        chk("stream_leftover", exp_q.size(), 0);
        if (!rnd)
            chk("stall_cycles_seen", stall_seen, 3);
    endtask

    initial begin
        //        a              b              cin   sub   sum            c     o     z
        tbl[0]  = '{32'd23,        32'd34,        1'b0, 1'b0, 32'd57,        1'b0, 1'b0, 1'b0};
        tbl[1]  = '{32'hFFFF_FFFF, 32'd1,         1'b0, 1'b0, 32'd0,         1'b1, 1'b0, 1'b1};
        tbl[2]  = '{32'h7FFF_FFFF, 32'd1,         1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1, 1'b0};
        tbl[3]  = '{32'd10,        32'd3,         1'b0, 1'b1, 32'd7,         1'b1, 1'b0, 1'b0};
        tbl[4]  = '{32'd3,         32'd10,        1'b0, 1'b1, 32'hFFFF_FFF9, 1'b0, 1'b0, 1'b0};
        tbl[5]  = '{32'd7,         32'd5,         1'b1, 1'b1, 32'd1,         1'b1, 1'b0, 1'b0};
        tbl[6]  = '{32'h8000_0000, 32'd1,         1'b0, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0};
        tbl[7]  = '{32'h0000_FFFF, 32'd0,         1'b1, 1'b0, 32'h0001_0000, 1'b0, 1'b0, 1'b0};
        tbl[8]  = '{32'd5,         32'd5,         1'b0, 1'b1, 32'd0,         1'b1, 1'b0, 1'b1};
        tbl[9]  = '{32'd0,         32'd0,         1'b0, 1'b0, 32'd0,         1'b0, 1'b0, 1'b1};
        tbl[10] = '{32'h1234_5678, 32'h8765_4321, 1'b0, 1'b0, 32'h9999_9999, 1'b0, 1'b0, 1'b0};

        tbl8[0] = '{32'h05, 32'h07, 1'b0, 1'b1, 32'hFE, 1'b0, 1'b0, 1'b0};
        tbl8[1] = '{32'h07, 32'h05, 1'b1, 1'b1, 32'h01, 1'b1, 1'b0, 1'b0};
        tbl8[2] = '{32'h7F, 32'h01, 1'b0, 1'b0, 32'h80, 1'b0, 1'b1, 1'b0};
        tbl8[3] = '{32'hFF, 32'h01, 1'b0, 1'b0, 32'h00, 1'b1, 1'b0, 1'b1};
        tbl8[4] = '{32'h0F, 32'h01, 1'b1, 1'b0, 32'h11, 1'b0, 1'b0, 1'b0};

        // Reset with an operand presented: it must be discarded
        resetn = 1'b0; out_ready = 1'b1;
        in_valid = 1'b1; a = 32'd9; b = 32'd9; cin = 1'b0; sub = 1'b0;
        in_valid8 = 1'b1; a8 = 8'd1; b8 = 8'd1; cin8 = 1'b0; sub8 = 1'b0;
        repeat (3) @(negedge clock);
        chk("reset_in_ready", in_ready, 1'b1);
        chk("reset_outputs", {out_valid, sum, cout, ovf, zero}, 36'd0);
        resetn = 1'b1; in_valid = 1'b0; in_valid8 = 1'b0;
        repeat (5) @(negedge clock);
        chk("reset_input_discarded", {out_valid, out_valid4, out_valid1}, 3'b000);

        // 32/2 directed vectors: exact 2-cycle latency
        for (int i = 0; i < 11; i++) begin
            in_valid = 1'b1; a = tbl[i].a; b = tbl[i].b; cin = tbl[i].cin; sub = tbl[i].sub;
            #1 chk($sformatf("vec%0d_in_ready", i), in_ready, 1'b1);
            @(negedge clock);
            in_valid = 1'b0;
            chk($sformatf("vec%0d_early", i), out_valid, 1'b0);
            @(negedge clock);
            chk($sformatf("vec%0d_result", i), {out_valid, sum, cout, ovf, zero},
                {1'b1, tbl[i].s, tbl[i].c, tbl[i].o, tbl[i].z});
            @(negedge clock);
        end

        // 8-bit vectors: 1-stage result after 1 cycle, 4-stage after exactly 4
        for (int i = 0; i < 5; i++) begin
            in_valid8 = 1'b1; a8 = tbl8[i].a[7:0]; b8 = tbl8[i].b[7:0];
            cin8 = tbl8[i].cin; sub8 = tbl8[i].sub;
            #1 chk($sformatf("v8_%0d_in_ready", i), {in_ready4, in_ready1}, 2'b11);
            @(negedge clock);
            in_valid8 = 1'b0;
            chk($sformatf("s1_%0d_result", i), {out_valid1, sum1, cout1, ovf1, zero1},
                {1'b1, tbl8[i].s[7:0], tbl8[i].c, tbl8[i].o, tbl8[i].z});
            repeat (2) @(negedge clock);
            chk($sformatf("s4_%0d_early", i), out_valid4, 1'b0);
            @(negedge clock);
            chk($sformatf("s4_%0d_result", i), {out_valid4, sum4, cout4, ovf4, zero4},
                {1'b1, tbl8[i].s[7:0], tbl8[i].c, tbl8[i].o, tbl8[i].z});
            @(negedge clock);
        end

        // Back-to-back stream with a 3-cycle consumer stall
        run_stream(10, 1'b0, 200);

        // Mid-flight reset: everything in flight is lost, no stale result afterwards
        @(negedge clock);
        out_ready = 1'b1; in_valid = 1'b1; a = 32'hFFFF_FFFF; b = 32'd1; cin = 1'b0; sub = 1'b0;
        @(negedge clock);
        a = 32'h7FFF_FFFF;
        @(negedge clock);
        chk("rst_inflight_present", out_valid, 1'b1);
        resetn = 1'b0; a = 32'd5; b = 32'd6;
        @(negedge clock);
        chk("rst_mid_outputs", {out_valid, sum, cout, ovf, zero}, 36'd0);
        chk("rst_mid_in_ready", in_ready, 1'b1);
        resetn = 1'b1; in_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            chk($sformatf("rst_no_stale%0d", i), out_valid, 1'b0);
        end
        in_valid = 1'b1; a = 32'd100; b = 32'd23;
        @(negedge clock);
        in_valid = 1'b0;
        chk("post_rst_early", out_valid, 1'b0);
        @(negedge clock);
        chk("post_rst_result", {out_valid, sum, cout, ovf, zero}, {1'b1, 32'd123, 3'b000});
        @(negedge clock);

        // Random operands, random producer and consumer pacing
        run_stream(10000, 1'b1, 60000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_pipe_add
`default_nettype wire
